// File: rtl/sata_rx_link_ctrl_if.sv
// Signal bundle between the SATA receive link controller and its neighbours
// (PHY receive path, FIS buffer, CRC checker, transmit primitive mux).
interface sata_rx_link_ctrl_if;
    // Handshake semantics: buf_ready is a level; while low the link asks the
    // far end to HOLD. crc_val is a one-cycle strobe and crc_ok is meaningful
    // only in that cycle. rx_datak qualifies every rx_data dword (1 = primitive).
    logic        link_up;
    logic [31:0] rx_data;
    logic        rx_datak;
    logic        buf_ready;
    logic        crc_val;
    logic        crc_ok;
    logic [31:0] tx_data;
    logic        tx_datak;
    logic        busy;
    logic        frame_good;
    logic        frame_bad;
    logic        frame_abort;
    logic [2:0]  state_dbg;

    modport master (
        output link_up, rx_data, rx_datak, buf_ready, crc_val, crc_ok,
        input  tx_data, tx_datak, busy, frame_good, frame_bad, frame_abort, state_dbg
    );

    modport slave (
        input  link_up, rx_data, rx_datak, buf_ready, crc_val, crc_ok,
        output tx_data, tx_datak, busy, frame_good, frame_bad, frame_abort, state_dbg
    );
endinterface

// File: rtl/sata_rx_link_ctrl.sv
// Receive-side SATA link-layer controller: answers the incoming primitive
// stream with SYNC/R_RDY/R_IP/HOLD/HOLDA/R_OK/R_ERR and flags frame outcome.
module sata_rx_link_ctrl #(
    parameter int CRC_TIMEOUT = 64
) (
    input logic                 clk,
    input logic                 reset,
    sata_rx_link_ctrl_if.slave  bus
);

    localparam logic        DWORD_IS_PRIM = 1'b1;
    localparam logic [31:0] SYNC_PRIM  = 32'hB5B5_957C;
    localparam logic [31:0] X_RDY_PRIM = 32'h5757_B57C;
    localparam logic [31:0] R_RDY_PRIM = 32'h4A4A_957C;
    localparam logic [31:0] SOF_PRIM   = 32'h3737_B57C;
    localparam logic [31:0] EOF_PRIM   = 32'hD5D5_B57C;
    localparam logic [31:0] R_IP_PRIM  = 32'h5555_B57C;
    localparam logic [31:0] HOLD_PRIM  = 32'hD5D5_AA7C;
    localparam logic [31:0] HOLDA_PRIM = 32'h9595_AA7C;
    localparam logic [31:0] R_OK_PRIM  = 32'h3535_B57C;
    localparam logic [31:0] R_ERR_PRIM = 32'h5656_B57C;

    localparam int CW = $clog2(CRC_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_RECEIVE, S_HOLD, S_CHECK, S_GOOD, S_BAD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     tx_q, tx_d;
    logic            busy_q;
    logic            good_q, good_d;
    logic            bad_q, bad_d;
    logic            abort_q, abort_d;
    logic            send_holda;

    logic rx_is_prim, rx_sync, rx_xrdy, rx_sof, rx_eof, rx_hold;
    logic in_frame, timeout_hit;

    // Data dwords never match because every primitive check requires datak.
    assign rx_is_prim  = (bus.rx_datak == DWORD_IS_PRIM);
    assign rx_sync     = rx_is_prim && (bus.rx_data == SYNC_PRIM);
    assign rx_xrdy     = rx_is_prim && (bus.rx_data == X_RDY_PRIM);
    assign rx_sof      = rx_is_prim && (bus.rx_data == SOF_PRIM);
    assign rx_eof      = rx_is_prim && (bus.rx_data == EOF_PRIM);
    assign rx_hold     = rx_is_prim && (bus.rx_data == HOLD_PRIM);
    assign in_frame    = (state_q == S_RECEIVE) || (state_q == S_HOLD) || (state_q == S_CHECK);
    assign timeout_hit = (cnt_q == CW'(CRC_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        good_d     = 1'b0;
        bad_d      = 1'b0;
        abort_d    = 1'b0;
        send_holda = 1'b0;
        if (!bus.link_up) begin
            state_d = S_IDLE;
            abort_d = in_frame;
        end else if (rx_sync) begin
            state_d = S_IDLE;
            abort_d = in_frame;
        end else begin
            case (state_q)
                S_IDLE:  if (rx_xrdy) state_d = S_READY;
                S_READY: if (rx_sof)  state_d = S_RECEIVE;
                S_RECEIVE: begin
                    // EOF outranks back-pressure: the frame is already complete.
                    if (rx_eof)              state_d = S_CHECK;
                    else if (!bus.buf_ready) state_d = S_HOLD;
                    else if (rx_hold)        send_holda = 1'b1;
                end
                S_HOLD: begin
                    if (rx_eof)             state_d = S_CHECK;
                    else if (bus.buf_ready) state_d = S_RECEIVE;
                end
                S_CHECK: begin
                    if (bus.crc_val) begin
                        state_d = bus.crc_ok ? S_GOOD : S_BAD;
                        good_d  = bus.crc_ok;
                        bad_d   = !bus.crc_ok;
                    end else if (timeout_hit) begin
                        state_d = S_BAD;
                        bad_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        case (state_d)
            S_READY:   tx_d = R_RDY_PRIM;
            S_RECEIVE: tx_d = send_holda ? HOLDA_PRIM : R_IP_PRIM;
            S_HOLD:    tx_d = HOLD_PRIM;
            S_CHECK:   tx_d = R_IP_PRIM;
            S_GOOD:    tx_d = R_OK_PRIM;
            S_BAD:     tx_d = R_ERR_PRIM;
            default:   tx_d = SYNC_PRIM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tx_q    <= SYNC_PRIM;
            busy_q  <= 1'b0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != S_IDLE);
            good_q  <= good_d;
            bad_q   <= bad_d;
            abort_q <= abort_d;
            // Counter restarts on every CHECK entry and saturates rather than wrapping.
            if (state_d == S_CHECK && state_q != S_CHECK)
                cnt_q <= '0;
            else if (state_q == S_CHECK && cnt_q != {CW{1'b1}})
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.tx_data     = tx_q;
    assign bus.tx_datak    = DWORD_IS_PRIM;
    assign bus.busy        = busy_q;
    assign bus.frame_good  = good_q;
    assign bus.frame_bad   = bad_q;
    assign bus.frame_abort = abort_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_sata_rx_link_ctrl.sv
// Scoreboarded bench for sata_rx_link_ctrl: directed frame scenarios followed
// by random primitive traffic, checked cycle by cycle against a frame model.
module tb_sata_rx_link_ctrl;

    localparam int          TIMEOUT = 4;
    localparam logic [31:0] P_SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] P_XRDY  = 32'h5757_B57C;
    localparam logic [31:0] P_RRDY  = 32'h4A4A_957C;
    localparam logic [31:0] P_SOF   = 32'h3737_B57C;
    localparam logic [31:0] P_EOF   = 32'hD5D5_B57C;
    localparam logic [31:0] P_RIP   = 32'h5555_B57C;
    localparam logic [31:0] P_HOLD  = 32'hD5D5_AA7C;
    localparam logic [31:0] P_HOLDA = 32'h9595_AA7C;
    localparam logic [31:0] P_ROK   = 32'h3535_B57C;
    localparam logic [31:0] P_RERR  = 32'h5656_B57C;
    localparam logic [31:0] P_WTRM  = 32'h5858_B57C;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sata_rx_link_ctrl_if bus ();

    sata_rx_link_ctrl #(.CRC_TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected vector: {tx_data, tx_datak, busy, frame_good, frame_bad, frame_abort}
    logic [36:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Frame model: where the receiver is in the conversation with the host.
    typedef enum int {
        M_IDLE, M_READY, M_DATA, M_PAUSED, M_VERDICT, M_ACCEPTED, M_REJECTED
    } phase_t;
    phase_t m_phase;
    int     m_wait;

    logic br_v   = 1'b1;
    logic link_v = 1'b1;

    task automatic model_step(input logic rst, input logic lnk, input logic [31:0] d,
                              input logic k, input logic br, input logic cv, input logic ck);
        phase_t prev;
        logic [31:0] tx;
        logic good, bad, abort, holda;
        good = 0; bad = 0; abort = 0; holda = 0;
        prev = m_phase;
        if (rst) begin
            m_phase = M_IDLE;
            m_wait  = 0;
        end else if (!lnk || (k && d == P_SYNC)) begin
            abort   = (prev == M_DATA || prev == M_PAUSED || prev == M_VERDICT);
            m_phase = M_IDLE;
        end else begin
            if (prev == M_IDLE && k && d == P_XRDY) m_phase = M_READY;
            if (prev == M_READY && k && d == P_SOF) m_phase = M_DATA;
            if (prev == M_DATA || prev == M_PAUSED) begin
                if (k && d == P_EOF) begin
                    m_phase = M_VERDICT;
                    m_wait  = 0;
                end else if (prev == M_DATA && !br) m_phase = M_PAUSED;
                else if (prev == M_PAUSED && br)   m_phase = M_DATA;
                else if (prev == M_DATA && k && d == P_HOLD) holda = 1;
            end
            if (prev == M_VERDICT) begin
                if (cv)                       m_phase = ck ? M_ACCEPTED : M_REJECTED;
                else if (m_wait + 1 >= TIMEOUT) m_phase = M_REJECTED;
                else                          m_wait++;
            end
            good = (prev != M_ACCEPTED) && (m_phase == M_ACCEPTED);
            bad  = (prev != M_REJECTED) && (m_phase == M_REJECTED);
        end
        case (m_phase)
            M_READY:    tx = P_RRDY;
            M_DATA:     tx = holda ? P_HOLDA : P_RIP;
            M_PAUSED:   tx = P_HOLD;
            M_VERDICT:  tx = P_RIP;
            M_ACCEPTED: tx = P_ROK;
            M_REJECTED: tx = P_RERR;
            default:    tx = P_SYNC;
        endcase
        exp_q.push_back({tx, 1'b1, (m_phase != M_IDLE), good, bad, abort});
    endtask

    // Drive one cycle of inputs (just after a falling edge) and record the expectation.
    task automatic step(input logic rst, input logic lnk, input logic [31:0] d, input logic k,
                        input logic br, input logic cv, input logic ck);
        reset         = rst;
        bus.link_up   = lnk;
        bus.rx_data   = d;
        bus.rx_datak  = k;
        bus.buf_ready = br;
        bus.crc_val   = cv;
        bus.crc_ok    = ck;
        model_step(rst, lnk, d, k, br, cv, ck);
        @(negedge clk);
    endtask

    task automatic prim(input logic [31:0] p, input int n);
        for (int i = 0; i < n; i++) step(1'b0, link_v, p, 1'b1, br_v, 1'b0, 1'b0);
    endtask

    task automatic data(input int n);
        for (int i = 0; i < n; i++) step(1'b0, link_v, $urandom, 1'b0, br_v, 1'b0, 1'b0);
    endtask

    task automatic crc(input logic ok);
        step(1'b0, link_v, P_WTRM, 1'b1, br_v, 1'b1, ok);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, P_SYNC, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        logic [36:0] e, a;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {bus.tx_data, bus.tx_datak, bus.busy, bus.frame_good, bus.frame_bad, bus.frame_abort};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t got tx=%h k=%b busy=%b good=%b bad=%b abort=%b required tx=%h k=%b busy=%b good=%b bad=%b abort=%b",
                         $time, a[36:5], a[4], a[3], a[2], a[1], a[0],
                         e[36:5], e[4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.link_up = 1'b1; bus.rx_data = P_SYNC; bus.rx_datak = 1'b1;
        bus.buf_ready = 1'b1; bus.crc_val = 1'b0; bus.crc_ok = 1'b0;
        m_phase = M_IDLE; m_wait = 0;
        @(negedge clk);
        do_reset(2);
        prim(P_SYNC, 2);

        // Clean frame with verdict two cycles after EOF.
        prim(P_XRDY, 3); prim(P_SOF, 1); data(8); prim(P_EOF, 1);
        prim(P_WTRM, 1); crc(1'b1); prim(P_WTRM, 3); prim(P_SYNC, 2);

        // Back-pressure for five cycles, plus a HOLD from the host.
        prim(P_XRDY, 1); prim(P_SOF, 1); data(3);
        br_v = 1'b0; data(5); br_v = 1'b1; data(2);
        prim(P_HOLD, 2); data(1);
        prim(P_EOF, 1); prim(P_WTRM, 1); crc(1'b1); prim(P_SYNC, 2);

        // CRC failure.
        prim(P_XRDY, 1); prim(P_SOF, 1); data(4); prim(P_EOF, 1);
        crc(1'b0); prim(P_WTRM, 3); prim(P_SYNC, 2);

        // Timeout without any verdict; late crc_val in BAD is ignored.
        prim(P_XRDY, 1); prim(P_SOF, 1); data(2); prim(P_EOF, 1);
        prim(P_WTRM, 6); crc(1'b1); prim(P_SYNC, 2);

        // SYNC during RECEIVE aborts.
        prim(P_XRDY, 1); prim(P_SOF, 1); data(3); prim(P_SYNC, 2);

        // link_up drop during HOLD aborts.
        prim(P_XRDY, 1); prim(P_SOF, 1); data(2);
        br_v = 1'b0; data(2); link_v = 1'b0; data(1); link_v = 1'b1; br_v = 1'b1;
        prim(P_SYNC, 2);

        // Reset during CHECK: back to SYNC, no abort.
        prim(P_XRDY, 1); prim(P_SOF, 1); data(2); prim(P_EOF, 1); prim(P_WTRM, 1);
        do_reset(1); prim(P_SYNC, 2);

        // EOF together with buf_ready low goes to CHECK.
        prim(P_XRDY, 1); prim(P_SOF, 1); data(2);
        br_v = 1'b0; prim(P_EOF, 1); br_v = 1'b1;
        crc(1'b1); prim(P_SYNC, 2);

        // Verdict on the timeout cycle wins.
        prim(P_XRDY, 1); prim(P_SOF, 1); data(2); prim(P_EOF, 1);
        prim(P_WTRM, TIMEOUT - 1); crc(1'b1); prim(P_SYNC, 2);

        // SYNC in READY: back to IDLE, no abort; stray crc_val in IDLE ignored.
        prim(P_XRDY, 2); prim(P_SYNC, 1); crc(1'b1); prim(P_SYNC, 1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            int r;
            logic [31:0] d;
            logic k;
            r = $urandom_range(0, 99);
            k = 1'b1;
            if (r < 10)      d = P_XRDY;
            else if (r < 18) d = P_SOF;
            else if (r < 24) d = P_EOF;
            else if (r < 27) d = P_SYNC;
            else if (r < 32) d = P_HOLD;
            else if (r < 38) d = P_WTRM;
            else if (r < 42) d = $urandom;
            else begin
                d = $urandom;
                k = 1'b0;
            end
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) != 0), d, k,
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end

        prim(P_SYNC, 2);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
